inventory_fsm: RTL and testbench
================================

Name: inventory_fsm

Overview:
Parametrised inventory tracker for the adventure-game datapath; generalises the single-item pickup FSM to NUM_ITEMS items.
- Each item lives in a configured room. It is picked up on entry into that room, subject to a carry limit.
- An item can be used (consumed, or kept if reusable) via a request/ack handshake.
- Sits beside the room-navigation FSM: consumes its registered curr_room and feeds item status to door/monster logic.

Parameters:
NUM_ITEMS, 4, number of tracked items (1..8)
ROOM_W, 3, width of room code
ITEM_ROOMS, {3'd6,3'd5,3'd5,3'd3}, packed NUM_ITEMS*ROOM_W vector; slice i = room holding item i (item0 = sword, room 3)
START_ROOM, 3'd0, room code loaded into the previous-room register at reset
MAX_CARRY, 2, maximum simultaneously held items (1..NUM_ITEMS)
REUSABLE, 4'b0001, bit i = 1 means item i stays held after use

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
curr_room  input  ROOM_W  current room code, synchronous to clk
use_req  input  1  single-cycle request to use item use_idx
use_idx  input  max(1,$clog2(NUM_ITEMS))  item index for use_req
has_item  output  NUM_ITEMS  bit i = item i currently held
used_item  output  NUM_ITEMS  bit i = item i used at least once (sticky)
pickup_pulse  output  NUM_ITEMS  one-cycle pulse when item i is acquired
use_ack  output  1  one-cycle pulse: use granted
use_nack  output  1  one-cycle pulse: use refused
carry_count  output  $clog2(MAX_CARRY+1)  number of held items
inv_full  output  1  carry_count == MAX_CARRY

Behaviour:
- Per-item 2-bit state: ABSENT, HELD, CONSUMED. Reset puts all items in ABSENT and prev_room = START_ROOM.
- All outputs reset to 0.
- Entry detect: entry = (curr_room != prev_room); prev_room <= curr_room every cycle. Remaining in a room never re-triggers pickup.
- Use handshake, evaluated on pre-edge state:
  - use_req with idx < NUM_ITEMS and item HELD: granted. use_ack pulses on the next cycle.
  - On grant, used_item[idx] is set in the same edge.
  - Non-reusable item: HELD -> CONSUMED, which frees a carry slot.
  - Reusable item: stays HELD.
  - Otherwise (idx out of range, ABSENT, or CONSUMED): use_nack pulses on the next cycle; no state change.
  - use_ack and use_nack are never asserted together.
- Pickup, on an entry cycle:
  - Candidates are items in ABSENT with ITEM_ROOMS[i] == curr_room.
  - Available slots = MAX_CARRY − carry_count + (1 if this cycle's use consumes an item).
  - Candidates are granted in ascending index order until slots are exhausted. Granted items go ABSENT -> HELD, and pickup_pulse[i] is registered for the next cycle.
  - Ungranted candidates remain ABSENT. They are retried only on a later re-entry into that room.
- CONSUMED is terminal until reset; no respawn.
- carry_count, inv_full and has_item are registered and reflect state after the edge. carry_count never exceeds MAX_CARRY.
- Latency: has_item updates at the edge that samples the entry. pickup_pulse, use_ack and use_nack are asserted during the following cycle.
- reset_n asserted mid-operation clears everything immediately (asynchronously), including pending pulses. The first entry after reset release is judged against START_ROOM.
- curr_room == START_ROOM at reset release with an item in that room: no pickup until the player leaves and re-enters.

Test Plan:
1. Reset, then curr_room 0 -> 3 -> expect pickup_pulse = 4'b0001 for one cycle; has_item = 0001; carry_count = 1. Hold room 3 for 10 cycles -> no further pulses.
2. From state 1, enter room 5 -> items 1 and 2 are candidates; only 1 slot free -> has_item = 0011, inv_full = 1. Go to room 0, use item1 (idx 1) -> use_ack; has_item = 0001; used_item = 0010. Re-enter room 5 -> item2 acquired, has_item = 0101.
3. Use item0 (reusable) three times -> three use_acks; has_item[0] stays 1; used_item[0] = 1. Use item1 again after it was consumed -> use_nack. Use idx 3 while absent -> use_nack.
4. Full (items 0 and 2 held), enter room 6 in the same cycle as use_req on item2 -> item2 CONSUMED and item3 acquired on the same edge; carry_count stays 2; use_ack and pickup_pulse[3] are both asserted next cycle.
5. Drop reset_n low mid-pulse (cycle after a pickup) -> all outputs read 0 immediately. Release with curr_room = 0 -> nothing acquired.
6. Parameter sweep NUM_ITEMS = 1, MAX_CARRY = 1, ITEM_ROOMS = 3'd3 -> reproduces single-sword behaviour with entry semantics: room 3 entry sets has_item = 1.

Source files
------------

// File: rtl/inventory_fsm.sv
// rtl/inventory_fsm.sv - multi-item inventory tracker with room-entry pickup and use handshake
//
// Purpose:
//   Tracks NUM_ITEMS items, each living in a fixed room (ITEM_ROOMS).
//   An item is picked up when the player enters its room, provided a
//   carry slot is free. Held items can be used through a single-cycle
//   request. The request is answered one cycle later by use_ack or use_nack.
//   Reusable items stay held after use; the others become CONSUMED for good.
//
// Ports:
//   clk          - system clock, rising edge
//   reset_n      - asynchronous active-low reset
//   curr_room    - registered room code from the navigation FSM
//   use_req      - single-cycle request to use item use_idx
//   use_idx      - index of the item to use
//   has_item     - bit i: item i currently held
//   used_item    - bit i: item i used at least once (sticky)
//   pickup_pulse - bit i: one-cycle pulse after item i is acquired
//   use_ack      - one-cycle pulse: last request granted
//   use_nack     - one-cycle pulse: last request refused
//   carry_count  - number of items currently held
//   inv_full     - carry_count == MAX_CARRY

module inventory_fsm #(
  parameter int                            NUM_ITEMS  = 4,
  parameter int                            ROOM_W     = 3,
  parameter logic [NUM_ITEMS*ROOM_W-1:0]   ITEM_ROOMS = {3'd6, 3'd5, 3'd5, 3'd3},
  parameter logic [ROOM_W-1:0]             START_ROOM = 3'd0,
  parameter int                            MAX_CARRY  = 2,
  parameter logic [NUM_ITEMS-1:0]          REUSABLE   = 4'b0001,
  localparam int                           IDX_W      = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1,
  localparam int                           CNT_W      = $clog2(MAX_CARRY + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ROOM_W-1:0]    curr_room,
  input  logic                 use_req,
  input  logic [IDX_W-1:0]     use_idx,
  output logic [NUM_ITEMS-1:0] has_item,
  output logic [NUM_ITEMS-1:0] used_item,
  output logic [NUM_ITEMS-1:0] pickup_pulse,
  output logic                 use_ack,
  output logic                 use_nack,
  output logic [CNT_W-1:0]     carry_count,
  output logic                 inv_full
);

  typedef enum logic [1:0] {
    ABSENT   = 2'd0,
    HELD     = 2'd1,
    CONSUMED = 2'd2
  } item_state_e;

  item_state_e            item_state_q [NUM_ITEMS];
  item_state_e            item_state_d [NUM_ITEMS];
  logic [ROOM_W-1:0]      prev_room_q;
  logic [ROOM_W-1:0]      prev_room_d;
  logic [NUM_ITEMS-1:0]   has_item_q, has_item_d;
  logic [NUM_ITEMS-1:0]   used_item_q, used_item_d;
  logic [NUM_ITEMS-1:0]   pickup_pulse_q, pickup_pulse_d;
  logic                   use_ack_q, use_ack_d;
  logic                   use_nack_q, use_nack_d;
  logic [CNT_W-1:0]       carry_count_q, carry_count_d;
  logic                   inv_full_q, inv_full_d;

  logic                   entry;
  logic [NUM_ITEMS-1:0]   use_grant_vec;
  logic [NUM_ITEMS-1:0]   use_consume_vec;
  logic                   use_grant;
  logic                   use_consume;
  int                     slots;
  int                     held_cnt;

  always_comb begin
    entry       = (curr_room != prev_room_q);
    prev_room_d = curr_room;

    // Decode the request as a one-hot grant vector. An index that matches
    // no item (out of range) simply produces no grant and is refused.
    use_grant_vec = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (use_req && (use_idx == IDX_W'(i)) && (item_state_q[i] == HELD)) begin
        use_grant_vec[i] = 1'b1;
      end
    end
    use_consume_vec = use_grant_vec & ~REUSABLE;
    use_grant       = |use_grant_vec;
    use_consume     = |use_consume_vec;

    use_ack_d   = use_grant;
    use_nack_d  = use_req && !use_grant;
    used_item_d = used_item_q | use_grant_vec;

    for (int i = 0; i < NUM_ITEMS; i++) begin
      item_state_d[i] = item_state_q[i];
      if (use_consume_vec[i]) begin
        item_state_d[i] = CONSUMED;
      end
    end

    // A slot freed by a same-cycle consuming use is immediately available
    // to a pickup on this edge, so the count never transiently overshoots.
    slots          = MAX_CARRY - int'(carry_count_q) + (use_consume ? 1 : 0);
    pickup_pulse_d = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (entry && (item_state_q[i] == ABSENT) &&
          (ITEM_ROOMS[i*ROOM_W +: ROOM_W] == curr_room) && (slots > 0)) begin
        item_state_d[i]   = HELD;
        pickup_pulse_d[i] = 1'b1;
        slots             = slots - 1;
      end
    end

    held_cnt   = 0;
    has_item_d = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (item_state_d[i] == HELD) begin
        has_item_d[i] = 1'b1;
        held_cnt      = held_cnt + 1;
      end
    end
    carry_count_d = CNT_W'(held_cnt);
    inv_full_d    = (held_cnt == MAX_CARRY);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        item_state_q[i] <= ABSENT;
      end
      prev_room_q    <= START_ROOM;
      has_item_q     <= '0;
      used_item_q    <= '0;
      pickup_pulse_q <= '0;
      use_ack_q      <= 1'b0;
      use_nack_q     <= 1'b0;
      carry_count_q  <= '0;
      inv_full_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        item_state_q[i] <= item_state_d[i];
      end
      prev_room_q    <= prev_room_d;
      has_item_q     <= has_item_d;
      used_item_q    <= used_item_d;
      pickup_pulse_q <= pickup_pulse_d;
      use_ack_q      <= use_ack_d;
      use_nack_q     <= use_nack_d;
      carry_count_q  <= carry_count_d;
      inv_full_q     <= inv_full_d;
    end
  end

  assign has_item     = has_item_q;
  assign used_item    = used_item_q;
  assign pickup_pulse = pickup_pulse_q;
  assign use_ack      = use_ack_q;
  assign use_nack     = use_nack_q;
  assign carry_count  = carry_count_q;
  assign inv_full     = inv_full_q;

endmodule

// File: tb/tb_inventory_fsm.sv
// tb/tb_inventory_fsm.sv - self-checking bench for inventory_fsm

module tb_inventory_fsm;

  logic       clk = 1'b0;
  logic       reset_n;

  // Default four-item instance
  logic [2:0] room;
  logic       req;
  logic [1:0] idx;
  logic [3:0] has, used, pulse;
  logic       ack, nack, full;
  logic [1:0] cnt;

  // Single-sword instance whose start room is the sword room
  logic [2:0] room1;
  logic       req1;
  logic [0:0] idx1;
  logic [0:0] has1, used1, pulse1;
  logic       ack1, nack1, full1;
  logic [0:0] cnt1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  inventory_fsm u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .curr_room    (room),
    .use_req      (req),
    .use_idx      (idx),
    .has_item     (has),
    .used_item    (used),
    .pickup_pulse (pulse),
    .use_ack      (ack),
    .use_nack     (nack),
    .carry_count  (cnt),
    .inv_full     (full)
  );

  inventory_fsm #(
    .NUM_ITEMS  (1),
    .ROOM_W     (3),
    .ITEM_ROOMS (3'd3),
    .START_ROOM (3'd3),
    .MAX_CARRY  (1),
    .REUSABLE   (1'b0)
  ) u_dut1 (
    .clk          (clk),
    .reset_n      (reset_n),
    .curr_room    (room1),
    .use_req      (req1),
    .use_idx      (idx1),
    .has_item     (has1),
    .used_item    (used1),
    .pickup_pulse (pulse1),
    .use_ack      (ack1),
    .use_nack     (nack1),
    .carry_count  (cnt1),
    .inv_full     (full1)
  );

  typedef struct {
    logic [2:0] room;
    logic       req;
    logic [1:0] idx;
    logic [3:0] has;
    logic [3:0] used;
    logic [3:0] pulse;
    logic       ack;
    logic       nack;
    logic [1:0] cnt;
    logic       full;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [2:0] r, input logic q, input logic [1:0] ix,
                              input logic [3:0] h, input logic [3:0] u, input logic [3:0] p,
                              input logic a, input logic n, input logic [1:0] c, input logic f);
    vec_t v;
    v.room = r; v.req = q; v.idx = ix; v.has = h; v.used = u; v.pulse = p;
    v.ack = a; v.nack = n; v.cnt = c; v.full = f;
    return v;
  endfunction

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, id, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_main(input int id, input logic [3:0] h, input logic [3:0] u, input logic [3:0] p,
                            input logic a, input logic n, input logic [1:0] c, input logic f);
    check("has_item", id, 32'(has), 32'(h));
    check("used_item", id, 32'(used), 32'(u));
    check("pickup_pulse", id, 32'(pulse), 32'(p));
    check("use_ack", id, 32'(ack), 32'(a));
    check("use_nack", id, 32'(nack), 32'(n));
    check("carry_count", id, 32'(cnt), 32'(c));
    check("inv_full", id, 32'(full), 32'(f));
  endtask

  task automatic check_sword(input int id, input logic h, input logic u, input logic p,
                             input logic a, input logic n, input logic c, input logic f);
    check("s_has_item", id, 32'(has1), 32'(h));
    check("s_used_item", id, 32'(used1), 32'(u));
    check("s_pickup_pulse", id, 32'(pulse1), 32'(p));
    check("s_use_ack", id, 32'(ack1), 32'(a));
    check("s_use_nack", id, 32'(nack1), 32'(n));
    check("s_carry_count", id, 32'(cnt1), 32'(c));
    check("s_inv_full", id, 32'(full1), 32'(f));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // room, req, idx | has, used, pulse, ack, nack, cnt, full
    vecs.push_back(mk(3'd0, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0));
    vecs.push_back(mk(3'd3, 1'b0, 2'd0, 4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b0, 2'd1, 1'b0));
    for (int k = 0; k < 10; k++)
      vecs.push_back(mk(3'd3, 1'b0, 2'd0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b0));
    vecs.push_back(mk(3'd5, 1'b0, 2'd0, 4'b0011, 4'b0000, 4'b0010, 1'b0, 1'b0, 2'd2, 1'b1));
    vecs.push_back(mk(3'd0, 1'b0, 2'd0, 4'b0011, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd2, 1'b1));
    vecs.push_back(mk(3'd0, 1'b1, 2'd1, 4'b0001, 4'b0010, 4'b0000, 1'b1, 1'b0, 2'd1, 1'b0));
    vecs.push_back(mk(3'd0, 1'b0, 2'd0, 4'b0001, 4'b0010, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b0));
    vecs.push_back(mk(3'd5, 1'b0, 2'd0, 4'b0101, 4'b0010, 4'b0100, 1'b0, 1'b0, 2'd2, 1'b1));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(3'd5, 1'b1, 2'd0, 4'b0101, 4'b0011, 4'b0000, 1'b1, 1'b0, 2'd2, 1'b1));
    vecs.push_back(mk(3'd5, 1'b1, 2'd1, 4'b0101, 4'b0011, 4'b0000, 1'b0, 1'b1, 2'd2, 1'b1));
    vecs.push_back(mk(3'd5, 1'b1, 2'd3, 4'b0101, 4'b0011, 4'b0000, 1'b0, 1'b1, 2'd2, 1'b1));
    vecs.push_back(mk(3'd5, 1'b0, 2'd0, 4'b0101, 4'b0011, 4'b0000, 1'b0, 1'b0, 2'd2, 1'b1));
    vecs.push_back(mk(3'd6, 1'b1, 2'd2, 4'b1001, 4'b0111, 4'b1000, 1'b1, 1'b0, 2'd2, 1'b1));
    vecs.push_back(mk(3'd6, 1'b0, 2'd0, 4'b1001, 4'b0111, 4'b0000, 1'b0, 1'b0, 2'd2, 1'b1));

    reset_n = 1'b0;
    room = 3'd0; req = 1'b0; idx = 2'd0;
    room1 = 3'd3; req1 = 1'b0; idx1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_main(0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    check_sword(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int v = 0; v < vecs.size(); v++) begin
      room = vecs[v].room;
      req  = vecs[v].req;
      idx  = vecs[v].idx;
      step();
      check_main(100 + v, vecs[v].has, vecs[v].used, vecs[v].pulse,
                 vecs[v].ack, vecs[v].nack, vecs[v].cnt, vecs[v].full);
    end
    req = 1'b0;

    // Sword instance sat in its own start room since reset: never picked up.
    check_sword(200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    room1 = 3'd0; step();
    check_sword(201, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    room1 = 3'd3; step();
    check_sword(202, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    check_sword(203, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    req1 = 1'b1; step();
    check_sword(204, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    req1 = 1'b0; room1 = 3'd5; step();
    room1 = 3'd3; step();
    check_sword(205, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    req1 = 1'b1; step();
    check_sword(206, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    req1 = 1'b0;

    // Asynchronous clear of a populated inventory, then release in room 3:
    // the first edge compares against START_ROOM (0), so the sword is taken.
    room = 3'd3;
    reset_n = 1'b0;
    #1;
    check_main(300, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check_main(301, 4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b0, 2'd1, 1'b0);

    // Reset while pickup_pulse is high clears it without waiting for a clock.
    reset_n = 1'b0;
    #1;
    check_main(302, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    room = 3'd0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_main(303 + k, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    end
    room = 3'd3; step();
    check_main(310, 4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b0, 2'd1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
